// File: rtl/dmem_lsu_ctrl_if.sv
// dmem_lsu_ctrl_if: valid/ready request and one-cycle response bus for the MEM-stage data memory
//   req_valid/req_ready  request handshake
//   req_write            1 = store, 0 = load
//   req_size             0 = byte, 1 = half, 2 = word, 3 = reserved
//   req_unsigned         loads: 1 = zero-extend, 0 = sign-extend
//   req_addr/req_wdata   byte address and store data
//   resp_valid           one-cycle response pulse
//   resp_rdata/resp_err  extended load data and fault flag
interface dmem_lsu_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;
    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_lsu_ctrl.sv
// dmem_lsu_ctrl: byte-addressable data memory with load/store unit and post-reset clear engine
//   clock   rising-edge clock
//   reset   synchronous, active-high; restarts the clear engine and drops any response
//   bus     dmem_lsu_ctrl_if slave (request handshake, registered response)
//   busy_o  high while the clear engine zeroes the array
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned accesses fault instead of being silently aligned.
module dmem_lsu_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic           clock,
    input  logic           reset,
    dmem_lsu_ctrl_if.slave bus,
    output logic           busy_o
);
    localparam int BYTES     = DATA_WIDTH / 8;
    localparam int OFF_W     = $clog2(BYTES);
    localparam int IDX_W     = ADDR_WIDTH - OFF_W;
    localparam int NUM_WORDS = 2 ** IDX_W;
    localparam int SH_W      = $clog2(DATA_WIDTH);

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];
    logic                  resp_valid_q;
    logic                  resp_err_q, resp_err_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;

    logic                  accept, err;
    logic [3:0]            nbytes;
    logic [ADDR_WIDTH-1:0] amask, addr;
    logic [IDX_W-1:0]      idx;
    logic [SH_W-1:0]       bit_off, sidx;
    logic [DATA_WIDTH-1:0] keep, wmask, wdata_sh, rd_sh, ext;
    logic                  sign;

    assign accept = bus.req_valid && state_q == IDLE;
    assign nbytes = 4'd1 << bus.req_size;
    assign amask  = ADDR_WIDTH'(nbytes - 4'd1);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign addr = bus.req_addr;
    assign err  = bus.req_size == 2'd3 || 32'(nbytes) > BYTES || |(bus.req_addr & amask);
`else
    assign addr = bus.req_addr & ~amask;
    assign err  = bus.req_size == 2'd3 || 32'(nbytes) > BYTES;
`endif

    assign idx      = addr[ADDR_WIDTH-1:OFF_W];
    // Low bits of {addr,000} are lane*8, the bit offset of the first accessed byte.
    assign bit_off  = SH_W'({addr, 3'b000});
    // Ones over the access width; a shift of DATA_WIDTH or more leaves the whole word.
    assign keep     = ~({DATA_WIDTH{1'b1}} << {nbytes, 3'b000});
    assign wmask    = keep << bit_off;
    assign wdata_sh = bus.req_wdata << bit_off;
    assign rd_sh    = mem_q[idx] >> bit_off;
    assign sidx     = SH_W'({nbytes, 3'b000} - 7'd1);
    assign sign     = ~bus.req_unsigned & rd_sh[sidx];
    assign ext      = (rd_sh & keep) | ({DATA_WIDTH{sign}} & ~keep);

    always_comb begin
        state_d      = (state_q == CLEAR && cnt_q == IDX_W'(NUM_WORDS - 1)) ? IDLE : state_q;
        cnt_d        = (state_q == CLEAR) ? cnt_q + IDX_W'(1) : cnt_q;
        resp_rdata_d = (err || bus.req_write) ? '0 : ext;
        resp_err_d   = err;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= CLEAR;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= accept;
            if (state_q == CLEAR)
                mem_q[cnt_q] <= '0;
            if (accept) begin
                resp_rdata_q <= resp_rdata_d;
                resp_err_q   <= resp_err_d;
                if (bus.req_write && !err)
                    mem_q[idx] <= (mem_q[idx] & ~wmask) | (wdata_sh & wmask);
            end
        end
    end

    assign bus.req_ready  = state_q == IDLE;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign busy_o         = state_q == CLEAR;
endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// tb_dmem_lsu_ctrl: directed checks of clear engine, stores, extended loads, faults and reset restart
module tb_dmem_lsu_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic busy;
    int   total = 0;
    int   bad   = 0;
    logic        rv, re;
    logic [31:0] rd;

    dmem_lsu_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus();

    dmem_lsu_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .busy_o(busy)
    );

    always #5 clock = ~clock;

    // Called at a falling edge: drives one request, lets the next rising edge accept it,
    // and captures the response at the following falling edge.
    task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                         input logic [7:0] a, input logic [31:0] d);
        bus.req_valid    = 1'b1;
        bus.req_write    = w;
        bus.req_size     = sz;
        bus.req_unsigned = u;
        bus.req_addr     = a;
        bus.req_wdata    = d;
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        @(negedge clock);
        rv = bus.resp_valid;
        rd = bus.resp_rdata;
        re = bus.resp_err;
    endtask

    task automatic test_reset;
        int n = 0;
        int viol = 0;
        @(negedge clock);
        reset = 1'b0;
        total++;
        if (bus.resp_valid !== 1'b0 || bus.resp_rdata !== 32'h0 || bus.resp_err !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_state: got v=%b d=%h e=%b busy=%b want v=0 d=00000000 e=0 busy=1",
                     bus.resp_valid, bus.resp_rdata, bus.resp_err, busy);
        end
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'd2;
        bus.req_unsigned = 1'b0; bus.req_addr = 8'hFC; bus.req_wdata = 32'h0;
        while (busy === 1'b1 && n < 200) begin
            if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0) viol++;
            n++;
            @(negedge clock);
        end
        total++;
        if (n !== 64 || viol !== 0 || bus.req_ready !== 1'b1) begin
            bad++;
            $display("FAIL clear_len: got cycles=%0d viol=%0d ready=%b want cycles=64 viol=0 ready=1",
                     n, viol, bus.req_ready);
        end
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        @(negedge clock);
        total++;
        if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h0 || bus.resp_err !== 1'b0) begin
            bad++;
            $display("FAIL first_load_fc: got v=%b d=%h e=%b want v=1 d=00000000 e=0",
                     bus.resp_valid, bus.resp_rdata, bus.resp_err);
        end
    endtask

    task automatic test_store_load;
        issue(1'b1, 2'd2, 1'b0, 8'h10, 32'h8899AABB);
        total++;
        if (rv !== 1'b1 || rd !== 32'h0 || re !== 1'b0) begin
            bad++;
            $display("FAIL st_w10: got v=%b d=%h e=%b want v=1 d=00000000 e=0", rv, rd, re);
        end
        issue(1'b1, 2'd0, 1'b0, 8'h11, 32'hFFFFFF7F);
        issue(1'b0, 2'd2, 1'b0, 8'h10, 32'h0);
        total++;
        if (rv !== 1'b1 || rd !== 32'h88997FBB || re !== 1'b0) begin
            bad++;
            $display("FAIL ld_w10: got v=%b d=%h e=%b want v=1 d=88997fbb e=0", rv, rd, re);
        end
        @(negedge clock);
        total++;
        if (bus.resp_valid !== 1'b0 || bus.resp_rdata !== 32'h88997FBB || bus.resp_err !== 1'b0) begin
            bad++;
            $display("FAIL hold: got v=%b d=%h e=%b want v=0 d=88997fbb e=0",
                     bus.resp_valid, bus.resp_rdata, bus.resp_err);
        end
    endtask

    task automatic test_extend;
        logic [1:0]  sz  [5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0};
        logic        un  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [7:0]  ad  [5] = '{8'h13, 8'h13, 8'h12, 8'h10, 8'h11};
        logic [31:0] exp [5] = '{32'hFFFFFF88, 32'h00000088, 32'hFFFF8899, 32'h00007FBB, 32'h0000007F};
        for (int i = 0; i < 5; i++) begin
            issue(1'b0, sz[i], un[i], ad[i], 32'h0);
            total++;
            if (rv !== 1'b1 || rd !== exp[i] || re !== 1'b0) begin
                bad++;
                $display("FAIL ext_%0d: got v=%b d=%h e=%b want v=1 d=%h e=0", i, rv, rd, re, exp[i]);
            end
        end
    endtask

    task automatic test_lanes;
        logic        w   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [1:0]  sz  [4] = '{2'd1, 2'd0, 2'd1, 2'd2};
        logic [7:0]  ad  [4] = '{8'h32, 8'h30, 8'h32, 8'h30};
        logic [31:0] wd  [4] = '{32'hDEADBEEF, 32'h123456AA, 32'h0, 32'h0};
        logic [31:0] exp [4] = '{32'h0, 32'h0, 32'hFFFFBEEF, 32'hBEEF00AA};
        for (int i = 0; i < 4; i++) begin
            issue(w[i], sz[i], 1'b0, ad[i], wd[i]);
            total++;
            if (rv !== 1'b1 || rd !== exp[i] || re !== 1'b0) begin
                bad++;
                $display("FAIL lane_%0d: got v=%b d=%h e=%b want v=1 d=%h e=0", i, rv, rd, re, exp[i]);
            end
        end
    endtask

    task automatic test_error;
        issue(1'b1, 2'd3, 1'b0, 8'h20, 32'hFFFFFFFF);
        total++;
        if (rv !== 1'b1 || rd !== 32'h0 || re !== 1'b1) begin
            bad++;
            $display("FAIL size3_st: got v=%b d=%h e=%b want v=1 d=00000000 e=1", rv, rd, re);
        end
        issue(1'b0, 2'd2, 1'b0, 8'h20, 32'h0);
        total++;
        if (rv !== 1'b1 || rd !== 32'h0 || re !== 1'b0) begin
            bad++;
            $display("FAIL size3_nowr: got v=%b d=%h e=%b want v=1 d=00000000 e=0", rv, rd, re);
        end
    endtask

    task automatic test_misalign;
        logic [31:0] exp_mem;
        logic        exp_e;
`ifdef DMEM_MISALIGN_TRAP_EN
        exp_mem = 32'h0;
        exp_e   = 1'b1;
`else
        exp_mem = 32'h00001234;
        exp_e   = 1'b0;
`endif
        issue(1'b1, 2'd1, 1'b0, 8'h21, 32'h00001234);
        total++;
        if (rv !== 1'b1 || rd !== 32'h0 || re !== exp_e) begin
            bad++;
            $display("FAIL mis_st: got v=%b d=%h e=%b want v=1 d=00000000 e=%b", rv, rd, re, exp_e);
        end
        issue(1'b0, 2'd2, 1'b0, 8'h20, 32'h0);
        total++;
        if (rv !== 1'b1 || rd !== exp_mem || re !== 1'b0) begin
            bad++;
            $display("FAIL mis_mem: got v=%b d=%h e=%b want v=1 d=%h e=0", rv, rd, re, exp_mem);
        end
        issue(1'b0, 2'd2, 1'b0, 8'h22, 32'h0);
        total++;
        if (rv !== 1'b1 || rd !== (exp_e ? 32'h0 : 32'h00001234) || re !== exp_e) begin
            bad++;
            $display("FAIL mis_ld: got v=%b d=%h e=%b want v=1 d=%h e=%b",
                     rv, rd, re, exp_e ? 32'h0 : 32'h00001234, exp_e);
        end
    endtask

    task automatic test_reset_mid_clear;
        int n = 0;
        logic [7:0] ad [4] = '{8'h10, 8'h30, 8'h20, 8'hFC};
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (10) @(negedge clock);
        total++;
        if (busy !== 1'b1 || bus.req_ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_clear_busy: got busy=%b ready=%b want busy=1 ready=0", busy, bus.req_ready);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clock);
        end
        total++;
        if (n !== 64 || bus.req_ready !== 1'b1) begin
            bad++;
            $display("FAIL restart_len: got cycles=%0d ready=%b want cycles=64 ready=1", n, bus.req_ready);
        end
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 2'd2, 1'b0, ad[i], 32'h0);
            total++;
            if (rv !== 1'b1 || rd !== 32'h0 || re !== 1'b0) begin
                bad++;
                $display("FAIL recleared_%0d: got v=%b d=%h e=%b want v=1 d=00000000 e=0", i, rv, rd, re);
            end
        end
    endtask

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 8'h0;
        bus.req_wdata    = 32'h0;
        test_reset();
        test_store_load();
        test_extend();
        test_lanes();
        test_error();
        test_misalign();
        test_reset_mid_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_lsu_ctrl.md
Name: dmem_lsu_ctrl

Overview:
Parametrised, byte-addressable data memory with an integrated load/store unit for the pipeline's MEM stage.
- Supports byte, half and word accesses, with byte-lane write enables and sign/zero extension on loads.
- Uses a valid/ready request interface and a registered one-cycle response.
- After every reset, a sequential clear engine zeroes the array one word per cycle; requests are refused until the clear completes.

Parameters:
- DATA_WIDTH, 32, word width in bits; legal values 8, 16, 32; BYTES = DATA_WIDTH/8.
- ADDR_WIDTH, 10, byte-address width; array holds NUM_WORDS = 2**ADDR_WIDTH / BYTES words.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data; the low (8<<req_size) bits are used.
- resp_valid  out  1  response pulse.
- resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- resp_err  out  1  access faulted.
- busy  out  1  clear engine running.

Behaviour:
- Reset (synchronous): state <= CLEAR, clear counter <= 0, resp_valid <= 0, resp_rdata <= 0, resp_err <= 0.
- Reset asserted mid-clear or mid-transaction restarts the clear from word 0. Any response in flight is dropped.
- State machine:
  - CLEAR: writes 0 to word[counter]; counter increments each cycle. At counter == NUM_WORDS-1 the word is cleared and state moves to IDLE next cycle.
  - CLEAR lasts exactly NUM_WORDS cycles after reset deasserts.
  - busy = (state == CLEAR); req_ready = (state == IDLE).
- Acceptance: a request is accepted when req_valid && req_ready. There is no response backpressure, so one request per cycle is sustained.
- Address split: word index = req_addr[ADDR_WIDTH-1:log2(BYTES)]; lane = req_addr[log2(BYTES)-1:0].
- Error conditions:
  - req_size == 3.
  - (1<<req_size) > BYTES.
  - Misalignment, subject to DMEM_MISALIGN_TRAP_EN (see Optional Feature).
- On error: no array write; the response carries resp_err = 1 and resp_rdata = 0.
- Store: byte lanes [lane .. lane+(1<<req_size)-1] of the addressed word take the corresponding low bytes of req_wdata. All other lanes are unchanged. The write occurs on the accept edge.
- Load: the addressed word is read on the accept edge. The selected lanes are shifted to bit 0 and sign- or zero-extended to DATA_WIDTH.
- Latency: resp_valid is high exactly one cycle after the accept cycle, and is 0 in all cycles without a preceding accept.
  - Loads return data in resp_rdata.
  - Stores return resp_rdata = 0, resp_err = 0.
- Ordering: a load accepted the cycle after a store to the same word returns the newly stored data.
- Outputs resp_rdata and resp_err hold their last values while resp_valid = 0. Reset clears them.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined: an access with (req_addr mod (1<<req_size)) != 0 is an error, with no write and resp_err = 1.
- Undefined: the low log2(1<<req_size) address bits are forced to 0 (silent alignment) and the access proceeds normally. Misalignment never raises resp_err.

Test Plan (DATA_WIDTH=32, ADDR_WIDTH=8, NUM_WORDS=64):
- Reset 1 cycle, then hold req_valid=1 -> busy=1 and req_ready=0 for exactly 64 cycles, then req_ready=1. A word load from 0xFC returns 0x00000000.
- Word store 0x8899AABB @0x10, then byte store 0x7F @0x11 -> word load @0x10 returns 0x88997FBB on the cycle after accept.
- Load byte @0x13, signed -> 0xFFFFFF88. Same load with unsigned -> 0x00000088. Half load @0x12, signed -> 0xFFFF8899.
- req_size=3 store @0x20 -> resp_err=1, resp_rdata=0, and the following word load @0x20 returns 0.
- Half store 0x1234 @0x21:
  - With DMEM_MISALIGN_TRAP_EN: resp_err=1 and memory is unchanged.
  - Without: the store writes @0x20, and a word load @0x20 returns 0x00001234.
- Assert reset on cycle 10 of the clear, with stored data present from earlier -> the clear restarts, busy stays high for 64 cycles after reset deasserts, and all loads then read 0.
